z4_serial_addsub: RTL

Parametrised, digit-serial successor of the 3-bit z4 adder benchmark. It accepts two W-bit operands plus a carry/borrow-in over a valid/ready handshake. It adds or subtracts them D bits per clock, LSB digit first, and presents the W-bit result plus carry-out on a second valid/ready handshake. It is the sequential reference block for the z4 family in the benchmark flow. Sweeping W and D trades area against latency while keeping the z4 add behaviour as the W=3 / sub=0 special case.

---
 rtl/z4_serial_addsub.sv | 115 +++++++++++
 1 files changed

// File: rtl/z4_serial_addsub.sv
// Digit-serial W-bit adder/subtractor: D bits per clock, LSB digit first,
// with valid/ready handshakes on operand and result sides.
module z4_serial_addsub #(
    parameter int W = 3,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (W < 1 || (W % D) != 0) begin : g_param_check
            $error("z4_serial_addsub: W must be >= 1 and a multiple of D");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic [D:0]    digit;

    function automatic logic [D:0] digit_add(input logic [D-1:0] x,
                                             input logic [D-1:0] y,
                                             input logic         c);
        return {1'b0, x} + {1'b0, y} + {{D{1'b0}}, c};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        digit     = digit_add(a_q[int'(cnt_q) * D +: D], b_q[int'(cnt_q) * D +: D], carry_q);

        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    // Subtraction is folded into the operands: invert b, seed carry with ~borrow.
                    a_d     = a;
                    b_d     = b ^ {W{sub}};
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q) * D +: D] = digit[D-1:0];
                carry_d = digit[D];
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = digit[D];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Operand and carry registers are only meaningful in RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        carry_q <= carry_d;
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
